// File: rtl/bonus_hit_scorer.sv
// Bonus ship hit responder: detects missile/bonus overlap, pulses the mover,
// hands a shot-count-dependent score to the accumulator and times the score pop-up.
module bonus_hit_scorer #(
    parameter int SHOW_FRAMES = 30,
    parameter int SCORE_W     = 48,
    parameter int SCREEN_W    = 640
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               playGame,
    input  logic               bonusAlive,
    input  logic               bonusDrawReq,
    input  logic               missileDrawReq,
    input  logic               missileFired,
    input  logic signed [10:0] bonusTopLeftX,
    output logic               bonusFireCollision,
    output logic               scoreValid,
    output logic [8:0]         scoreValue,
    input  logic               scoreReady,
    output logic               showScore,
    output logic signed [10:0] scoreX
);

    typedef enum logic [1:0] {IDLE, ARMED, HIT, SHOW} state_t;

    localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - SCORE_W);
    localparam logic [7:0]         FRAMES_END = 8'(SHOW_FRAMES);

    state_t             state;
    logic [3:0]         shot_idx;
    logic [7:0]         frame_cnt;
    logic [7:0]         frame_nxt;
    logic               overlap;
    logic signed [10:0] x_clamped;
    logic [8:0]         award;

    assign overlap = bonusDrawReq & missileDrawReq & bonusAlive;

    always_comb begin
        x_clamped = bonusTopLeftX;
        if (bonusTopLeftX < 11'sd0)
            x_clamped = 11'sd0;
        else if (bonusTopLeftX > X_MAX)
            x_clamped = X_MAX;
    end

    // Award uses the registered index, so a shot in the overlap cycle does not count yet.
    always_comb begin
        case (shot_idx)
            4'd0:    award = 9'd100;
            4'd1:    award = 9'd50;
            4'd2:    award = 9'd50;
            4'd3:    award = 9'd100;
            4'd4:    award = 9'd150;
            4'd5:    award = 9'd100;
            4'd6:    award = 9'd100;
            4'd7:    award = 9'd50;
            4'd8:    award = 9'd300;
            4'd9:    award = 9'd100;
            4'd10:   award = 9'd100;
            4'd11:   award = 9'd100;
            4'd12:   award = 9'd50;
            4'd13:   award = 9'd150;
            default: award = 9'd100;
        endcase
    end

    // Counter saturates at the end value so an expired-but-alive SHOW stays expired.
    assign frame_nxt = (startOfFrame && frame_cnt != FRAMES_END) ? frame_cnt + 8'd1 : frame_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            shot_idx           <= 4'd0;
            frame_cnt          <= 8'd0;
            bonusFireCollision <= 1'b0;
            scoreValid         <= 1'b0;
            scoreValue         <= 9'd0;
            showScore          <= 1'b0;
            scoreX             <= 11'sd0;
        end else if (!playGame) begin
            state              <= IDLE;
            shot_idx           <= 4'd0;
            frame_cnt          <= 8'd0;
            bonusFireCollision <= 1'b0;
            scoreValid         <= 1'b0;
            scoreValue         <= 9'd0;
            showScore          <= 1'b0;
            scoreX             <= 11'sd0;
        end else begin
            bonusFireCollision <= 1'b0;
            if (missileFired)
                shot_idx <= (shot_idx == 4'd14) ? 4'd0 : shot_idx + 4'd1;
            if (scoreValid && scoreReady)
                scoreValid <= 1'b0;

            case (state)
                IDLE: begin
                    showScore <= 1'b0;
                    if (bonusAlive)
                        state <= ARMED;
                end
                ARMED: begin
                    if (overlap) begin
                        state              <= HIT;
                        bonusFireCollision <= 1'b1;
                        scoreValid         <= 1'b1;
                        scoreValue         <= award;
                        scoreX             <= x_clamped;
                    end else if (!bonusAlive) begin
                        state <= IDLE;
                    end
                end
                HIT: begin
                    state     <= SHOW;
                    showScore <= 1'b1;
                    frame_cnt <= 8'd0;
                end
                SHOW: begin
                    frame_cnt <= frame_nxt;
                    if (frame_nxt == FRAMES_END) begin
                        showScore <= 1'b0;
                        if (!bonusAlive)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bonus_hit_scorer.sv
// Directed bench for bonus_hit_scorer: vector table of hits plus handshake,
// frame-timer, clear and reset sequences.
module tb_bonus_hit_scorer;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               playGame;
    logic               bonusAlive;
    logic               bonusDrawReq;
    logic               missileDrawReq;
    logic               missileFired;
    logic signed [10:0] bonusTopLeftX;
    logic               bonusFireCollision;
    logic               scoreValid;
    logic [8:0]         scoreValue;
    logic               scoreReady;
    logic               showScore;
    logic signed [10:0] scoreX;

    int passed = 0;
    int total  = 0;

    bonus_hit_scorer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
        .bonusAlive(bonusAlive), .bonusDrawReq(bonusDrawReq), .missileDrawReq(missileDrawReq),
        .missileFired(missileFired), .bonusTopLeftX(bonusTopLeftX),
        .bonusFireCollision(bonusFireCollision), .scoreValid(scoreValid),
        .scoreValue(scoreValue), .scoreReady(scoreReady), .showScore(showScore),
        .scoreX(scoreX)
    );

    always #5 clk = ~clk;

    typedef struct {
        int shots;
        int x;
        int exp_value;
        int exp_x;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic frame_pulse();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    // Returns with the DUT in HIT (edge after the overlap cycle just taken).
    task automatic do_hit(input bit clr, input int shots, input int x, input bit fire_at_overlap);
        bonusAlive = 1'b0;
        if (clr) playGame = 1'b0;
        step();
        playGame = 1'b1;
        for (int i = 0; i < shots; i++) begin
            missileFired = 1'b1;
            step();
        end
        missileFired = 1'b0;
        bonusAlive   = 1'b1;
        step();
        bonusTopLeftX  = 11'(x);
        bonusDrawReq   = 1'b1;
        missileDrawReq = 1'b1;
        missileFired   = fire_at_overlap;
        #3;
        chk("no_pulse_in_overlap_cycle", int'(bonusFireCollision), 0);
        step();
        bonusDrawReq   = 1'b0;
        missileDrawReq = 1'b0;
        missileFired   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0,   100, 100, 100};
        vecs[1] = '{8,   200, 300, 200};
        vecs[2] = '{16,  300, 50,  300};
        vecs[3] = '{0,   620, 100, 592};
        vecs[4] = '{0,   -10, 100, 0};
        vecs[5] = '{4,   592, 150, 592};
        vecs[6] = '{13,  0,   150, 0};
        vecs[7] = '{14,  593, 100, 592};
        vecs[8] = '{15,  50,  100, 50};
        vecs[9] = '{12,  -1,  50,  0};

        resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b1; bonusAlive = 1'b0;
        bonusDrawReq = 1'b0; missileDrawReq = 1'b0; missileFired = 1'b0;
        bonusTopLeftX = 11'sd0; scoreReady = 1'b0;
        step();
        chk("reset_collision", int'(bonusFireCollision), 0);
        chk("reset_valid", int'(scoreValid), 0);
        chk("reset_value", int'(scoreValue), 0);
        chk("reset_show", int'(showScore), 0);
        chk("reset_x", int'(scoreX), 0);
        #2 resetN = 1'b1;
        step();

        foreach (vecs[k]) begin
            do_hit(1'b1, vecs[k].shots, vecs[k].x, 1'b0);
            chk($sformatf("v%0d_pulse", k), int'(bonusFireCollision), 1);
            chk($sformatf("v%0d_valid", k), int'(scoreValid), 1);
            chk($sformatf("v%0d_value", k), int'(scoreValue), vecs[k].exp_value);
            chk($sformatf("v%0d_x", k), int'($signed(scoreX)), vecs[k].exp_x);
            step();
            chk($sformatf("v%0d_pulse_one_cycle", k), int'(bonusFireCollision), 0);
            chk($sformatf("v%0d_show", k), int'(showScore), 1);
            scoreReady = 1'b1;
            step();
            scoreReady = 1'b0;
            chk($sformatf("v%0d_accepted", k), int'(scoreValid), 0);
        end

        // Stall: award held stable until accepted, one transfer only.
        do_hit(1'b1, 3, 100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", int'(scoreValid), 1);
            chk("stall_value", int'(scoreValue), 100);
        end
        scoreReady = 1'b1;
        step();
        chk("stall_accept", int'(scoreValid), 0);
        step();
        scoreReady = 1'b0;
        chk("stall_stays_low", int'(scoreValid), 0);

        // Shot in the overlap cycle uses pre-increment index 7 -> 50.
        do_hit(1'b1, 7, 100, 1'b1);
        chk("coincident_fire_value", int'(scoreValue), 50);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        scoreReady = 1'b1;
        step();
        scoreReady = 1'b0;
        bonusDrawReq = 1'b1; missileDrawReq = 1'b1;
        step();
        bonusDrawReq = 1'b0; missileDrawReq = 1'b0;
        chk("show_overlap_no_pulse", int'(bonusFireCollision), 0);
        chk("show_overlap_no_award", int'(scoreValid), 0);
        bonusAlive = 1'b0;
        for (int i = 0; i < 29; i++) frame_pulse();
        chk("show_after_29", int'(showScore), 1);
        frame_pulse();
        chk("show_after_30", int'(showScore), 0);
        do_hit(1'b0, 0, 100, 1'b0);
        chk("rehit_pulse", int'(bonusFireCollision), 1);
        chk("rehit_idx8_value", int'(scoreValue), 300);
        step();

        // Timer expires with ship still alive: hidden, no re-hit until it leaves.
        for (int i = 0; i < 30; i++) frame_pulse();
        chk("expired_alive_hidden", int'(showScore), 0);
        bonusDrawReq = 1'b1; missileDrawReq = 1'b1;
        step();
        bonusDrawReq = 1'b0; missileDrawReq = 1'b0;
        chk("expired_alive_no_pulse", int'(bonusFireCollision), 0);
        do_hit(1'b0, 0, 100, 1'b0);
        chk("after_leave_pulse", int'(bonusFireCollision), 1);
        step();

        // playGame drop clears everything, including the shot index.
        do_hit(1'b1, 2, 700, 1'b0);
        step();
        chk("pre_clear_valid", int'(scoreValid), 1);
        playGame = 1'b0;
        step();
        playGame = 1'b1;
        chk("clear_valid", int'(scoreValid), 0);
        chk("clear_value", int'(scoreValue), 0);
        chk("clear_show", int'(showScore), 0);
        chk("clear_x", int'(scoreX), 0);
        do_hit(1'b0, 0, 100, 1'b0);
        chk("clear_idx_value", int'(scoreValue), 100);
        step();

        // Asynchronous reset mid-SHOW.
        do_hit(1'b1, 4, 300, 1'b0);
        step();
        chk("pre_reset_show", int'(showScore), 1);
        #2 resetN = 1'b0;
        #1;
        chk("async_show", int'(showScore), 0);
        chk("async_valid", int'(scoreValid), 0);
        chk("async_value", int'(scoreValue), 0);
        chk("async_x", int'(scoreX), 0);
        #3 resetN = 1'b1;
        do_hit(1'b0, 0, 100, 1'b0);
        chk("reset_idx_value", int'(scoreValue), 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
